// File: rtl/branch_predict_ctrl.sv
// -----------------------------------------------------------------------------
// branch_predict_ctrl
//
// Branch prediction and mispredict recovery for the 5-stage pipeline.
//  - IF side : predicts direction from a table of 2-bit saturating counters
//              (BHT) indexed by PC[IDX_BITS+1:2] and produces the next PC.
//  - EX side : compares the resolved direction with the prediction carried
//              down the pipe, trains the BHT, and on a mismatch issues a
//              one-cycle Redirect and holds Flush for FLUSH_CYC unstalled
//              cycles.
//
// Ports
//  clk, rst_n         clock (rising edge), asynchronous active-low reset
//  IfPC/IfBranch/IfTarget   IF instruction PC, branch predecode, target
//  PredTaken/PredPC         combinational prediction and next fetch PC
//  Stall                    global stall; freezes EX acceptance and the FSM
//  ExValid/ExBranch/ExTaken/ExPredTaken/ExPC/ExTarget  EX branch resolution
//  Redirect/RedirectPC      registered fetch redirect pulse and corrected PC
//  Flush                    registered squash of IF/ID and ID/EX
//  BranchCnt/MispredCnt     performance counters
//
// Build option
//  BRANCH_PERF_CNT_EN : when defined, BranchCnt/MispredCnt count resolves and
//                       mispredicts (32-bit, wrapping). When undefined both
//                       outputs are tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module branch_predict_ctrl #(
  parameter int PC_W      = 32,
  parameter int IDX_BITS  = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] IfPC,
  input  logic            IfBranch,
  input  logic [PC_W-1:0] IfTarget,
  output logic            PredTaken,
  output logic [PC_W-1:0] PredPC,
  input  logic            Stall,
  input  logic            ExValid,
  input  logic            ExBranch,
  input  logic            ExTaken,
  input  logic            ExPredTaken,
  input  logic [PC_W-1:0] ExPC,
  input  logic [PC_W-1:0] ExTarget,
  output logic            Redirect,
  output logic [PC_W-1:0] RedirectPC,
  output logic            Flush,
  output logic [31:0]     BranchCnt,
  output logic [31:0]     MispredCnt
);

  localparam int ENTRIES = 1 << IDX_BITS;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Saturating 2-bit counter step: up on taken, down on not-taken.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return res;
  endfunction

  logic [1:0]          bht_q [ENTRIES];
  logic [1:0]          bht_upd_d;
  state_e              state_q;
  logic [2:0]          flush_cnt_q;
  logic                redirect_q;
  logic [PC_W-1:0]     redirect_pc_q;
  logic                flush_q;

  logic [IDX_BITS-1:0] if_idx_s;
  logic [IDX_BITS-1:0] ex_idx_s;
  logic                resolve_s;
  logic                mispred_s;
  logic                unused_pc_bits;

  assign if_idx_s = IfPC[IDX_BITS+1:2];
  assign ex_idx_s = ExPC[IDX_BITS+1:2];
  // Bits outside the index field do not affect the table lookup.
  assign unused_pc_bits = ^{IfPC[PC_W-1:IDX_BITS+2], IfPC[1:0]};

  // Prediction reads the current (pre-update) counter; no write bypass.
  assign PredTaken = IfBranch & bht_q[if_idx_s][1];
  assign PredPC    = PredTaken ? IfTarget : (IfPC + PC_W'(4));

  // EX resolution is only accepted in IDLE: during a flush EX is wrong-path.
  assign resolve_s = ExValid & ExBranch & ~Stall & (state_q == ST_IDLE);
  assign mispred_s = resolve_s & (ExTaken != ExPredTaken);
  assign bht_upd_d = sat_update(bht_q[ex_idx_s], ExTaken);

  // BHT storage: reset to weakly not-taken, trained on every resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (resolve_s) begin
      bht_q[ex_idx_s] <= bht_upd_d;
    end
  end

  // Mispredict recovery FSM with registered Redirect/RedirectPC/Flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      flush_cnt_q   <= 3'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= {PC_W{1'b0}};
      flush_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mispred_s) begin
            state_q       <= ST_FLUSH;
            flush_cnt_q   <= 3'(FLUSH_CYC - 1);
            redirect_q    <= 1'b1;
            redirect_pc_q <= ExTaken ? ExTarget : (ExPC + PC_W'(4));
            flush_q       <= 1'b1;
          end else begin
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
          end
        end
        ST_FLUSH: begin
          redirect_q <= 1'b0;
          // Stall freezes both Flush and the remaining count.
          if (!Stall) begin
            if (flush_cnt_q == 3'd0) begin
              state_q <= ST_IDLE;
              flush_q <= 1'b0;
            end else begin
              flush_cnt_q <= flush_cnt_q - 3'd1;
              flush_q     <= 1'b1;
            end
          end else begin
            flush_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          flush_cnt_q <= 3'd0;
          redirect_q  <= 1'b0;
          flush_q     <= 1'b0;
        end
      endcase
    end
  end

  assign Redirect   = redirect_q;
  assign RedirectPC = redirect_pc_q;
  assign Flush      = flush_q;

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;

  // Performance counters; free-running and wrapping at 2**32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      if (resolve_s) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (mispred_s) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign BranchCnt  = branch_cnt_q;
  assign MispredCnt = mispred_cnt_q;
`else
  assign BranchCnt  = 32'd0;
  assign MispredCnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
module tb_branch_predict_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] IfPC;
  logic        IfBranch;
  logic [31:0] IfTarget;
  logic        PredTaken;
  logic [31:0] PredPC;
  logic        Stall;
  logic        ExValid;
  logic        ExBranch;
  logic        ExTaken;
  logic        ExPredTaken;
  logic [31:0] ExPC;
  logic [31:0] ExTarget;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Flush;
  logic [31:0] BranchCnt;
  logic [31:0] MispredCnt;

  int checks;
  int errors;

  branch_predict_ctrl #(.PC_W(32), .IDX_BITS(4), .FLUSH_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .IfPC(IfPC), .IfBranch(IfBranch), .IfTarget(IfTarget),
    .PredTaken(PredTaken), .PredPC(PredPC),
    .Stall(Stall), .ExValid(ExValid), .ExBranch(ExBranch),
    .ExTaken(ExTaken), .ExPredTaken(ExPredTaken),
    .ExPC(ExPC), .ExTarget(ExTarget),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .Flush(Flush),
    .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic taken, input logic pred,
                        input logic [31:0] tgt);
    ExValid = 1'b1; ExBranch = 1'b1; ExPC = pc;
    ExTaken = taken; ExPredTaken = pred; ExTarget = tgt;
  endtask

  task automatic clear_ex();
    ExValid = 1'b0; ExBranch = 1'b0;
  endtask

  // Bounded wait for Flush to drop.
  task automatic wait_flush();
    int n;
    n = 0;
    while (Flush === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (Flush !== 1'b0) begin
      errors++;
      $display("FAIL flush_timeout got %b exp 0", Flush);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Stall = 1'b0; clear_ex();
    IfBranch = 1'b1; IfPC = 32'h40; IfTarget = 32'h200;
    ExPC = 32'h0; ExTarget = 32'h0; ExTaken = 1'b0; ExPredTaken = 1'b0;
    #12;
    checks++;
    if ({Redirect, Flush} !== 2'b00 || RedirectPC !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got r=%b f=%b pc=%h exp 0 0 0", Redirect, Flush, RedirectPC);
    end
    checks++;
    if (BranchCnt !== 32'd0 || MispredCnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters got %h %h exp 0 0", BranchCnt, MispredCnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (PredTaken !== 1'b0 || PredPC !== 32'h44) begin
      errors++;
      $display("FAIL reset_predict got %b %h exp 0 00000044", PredTaken, PredPC);
    end
    for (int i = 0; i < 16; i++) begin
      IfPC = 32'(i) << 2;
      #1;
      checks++;
      if (PredTaken !== 1'b0) begin
        errors++;
        $display("FAIL reset_bht_idx%0d got %b exp 0", i, PredTaken);
      end
    end
    IfBranch = 1'b0; IfPC = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (PredPC !== 32'h0) begin
      errors++;
      $display("FAIL predpc_wrap got %h exp 00000000", PredPC);
    end
  endtask

  task automatic test_mispredict();
    set_ex(32'h40, 1'b1, 1'b0, 32'h100);
    tick();
    clear_ex();
    checks++;
    if (Redirect !== 1'b1 || RedirectPC !== 32'h100 || Flush !== 1'b1) begin
      errors++;
      $display("FAIL mispred_redirect got r=%b pc=%h f=%b exp 1 00000100 1", Redirect, RedirectPC, Flush);
    end
    tick();
    checks++;
    if (Redirect !== 1'b0 || Flush !== 1'b1) begin
      errors++;
      $display("FAIL mispred_cycle2 got r=%b f=%b exp 0 1", Redirect, Flush);
    end
    tick();
    checks++;
    if (Flush !== 1'b0) begin
      errors++;
      $display("FAIL mispred_flush_end got %b exp 0", Flush);
    end
    IfBranch = 1'b1; IfPC = 32'h40; IfTarget = 32'h300;
    #1;
    checks++;
    if (PredTaken !== 1'b1 || PredPC !== 32'h300) begin
      errors++;
      $display("FAIL trained_predict got %b %h exp 1 00000300", PredTaken, PredPC);
    end
    IfBranch = 1'b0;
    #1;
    checks++;
    if (PredTaken !== 1'b0 || PredPC !== 32'h44) begin
      errors++;
      $display("FAIL nonbranch_predict got %b %h exp 0 00000044", PredTaken, PredPC);
    end
  endtask

  task automatic test_saturate();
    IfBranch = 1'b1; IfPC = 32'h40;
    for (int i = 0; i < 4; i++) begin
      set_ex(32'h40, 1'b1, 1'b1, 32'h100);
      tick();
      clear_ex();
      checks++;
      if (Redirect !== 1'b0 || Flush !== 1'b0 || PredTaken !== 1'b1) begin
        errors++;
        $display("FAIL sat_taken%0d got r=%b f=%b p=%b exp 0 0 1", i, Redirect, Flush, PredTaken);
      end
    end
    // 11 -> 10: still predicts taken.
    set_ex(32'h40, 1'b0, 1'b1, 32'h100);
    tick();
    clear_ex();
    checks++;
    if (Redirect !== 1'b1 || RedirectPC !== 32'h44) begin
      errors++;
      $display("FAIL sat_nt_redirect got %b %h exp 1 00000044", Redirect, RedirectPC);
    end
    wait_flush();
    checks++;
    if (PredTaken !== 1'b1) begin
      errors++;
      $display("FAIL sat_after_one_nt got %b exp 1", PredTaken);
    end
    // 10 -> 01: now predicts not-taken.
    set_ex(32'h40, 1'b0, 1'b1, 32'h100);
    tick();
    clear_ex();
    wait_flush();
    checks++;
    if (PredTaken !== 1'b0) begin
      errors++;
      $display("FAIL sat_after_two_nt got %b exp 0", PredTaken);
    end
  endtask

  task automatic test_stall_flush();
    int fl;
    int rd;
    fl = 0; rd = 0;
    IfBranch = 1'b1; IfPC = 32'h48;
    set_ex(32'h48, 1'b1, 1'b0, 32'h1000);
    tick();
    checks++;
    if (RedirectPC !== 32'h1000) begin
      errors++;
      $display("FAIL stall_redirect_pc got %h exp 00001000", RedirectPC);
    end
    // Wrong-path mispredicting branch held in EX for the whole flush.
    set_ex(32'h48, 1'b1, 1'b0, 32'h2000);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      if (Flush === 1'b1) fl++;
      if (Redirect === 1'b1) rd++;
      Stall = (k < 3) ? 1'b1 : 1'b0;
      if (Flush !== 1'b1) clear_ex();
    end
    clear_ex(); Stall = 1'b0;
    checks++;
    if (fl != 5) begin
      errors++;
      $display("FAIL stall_flush_len got %0d exp 5", fl);
    end
    checks++;
    if (rd != 1 || RedirectPC !== 32'h1000) begin
      errors++;
      $display("FAIL stall_single_redirect got %0d %h exp 1 00001000", rd, RedirectPC);
    end
    // idx2 should be 10; one not-taken brings it to 01.
    set_ex(32'h48, 1'b0, 1'b1, 32'h2000);
    tick();
    clear_ex();
    wait_flush();
    checks++;
    if (PredTaken !== 1'b0) begin
      errors++;
      $display("FAIL stall_bht_untouched got %b exp 0", PredTaken);
    end
  endtask

  task automatic test_reset_mid_flush();
    IfBranch = 1'b1; IfPC = 32'h4C;
    set_ex(32'h4C, 1'b1, 1'b0, 32'h500);
    tick();
    clear_ex();
    checks++;
    if (Flush !== 1'b1 || PredTaken !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got f=%b p=%b exp 1 1", Flush, PredTaken);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Flush !== 1'b0 || Redirect !== 1'b0 || RedirectPC !== 32'h0 || PredTaken !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got f=%b r=%b pc=%h p=%b exp 0 0 0 0", Flush, Redirect, RedirectPC, PredTaken);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (Flush !== 1'b0 || Redirect !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle got f=%b r=%b exp 0 0", Flush, Redirect);
    end
  endtask

  task automatic test_back_to_back();
    IfBranch = 1'b1;
    set_ex(32'h50, 1'b0, 1'b0, 32'h0);
    tick();
    IfPC = 32'h54;
    set_ex(32'h54, 1'b1, 1'b1, 32'h0);
    #1;
    checks++;
    if (PredTaken !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass got %b exp 0", PredTaken);
    end
    tick();
    clear_ex();
    checks++;
    if (PredTaken !== 1'b1 || Redirect !== 1'b0 || Flush !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idx5 got p=%b r=%b f=%b exp 1 0 0", PredTaken, Redirect, Flush);
    end
    // idx4 went 01 -> 00; one taken only reaches 01.
    set_ex(32'h50, 1'b1, 1'b1, 32'h0);
    tick();
    clear_ex();
    IfPC = 32'h50;
    #1;
    checks++;
    if (PredTaken !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idx4_floor got %b exp 0", PredTaken);
    end
  endtask

  task automatic test_stall_idle();
    int rd;
    rd = 0;
    Stall = 1'b1;
    set_ex(32'h58, 1'b1, 1'b0, 32'h800);
    tick();
    tick();
    checks++;
    if (Redirect !== 1'b0 || Flush !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle_suppress got r=%b f=%b exp 0 0", Redirect, Flush);
    end
    Stall = 1'b0;
    tick();
    clear_ex();
    if (Redirect === 1'b1) rd++;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (Redirect === 1'b1) rd++;
    end
    checks++;
    if (rd != 1 || RedirectPC !== 32'h800) begin
      errors++;
      $display("FAIL stall_idle_release got %0d %h exp 1 00000800", rd, RedirectPC);
    end
  endtask

  task automatic test_perf_cnt();
    logic [31:0] exp_b;
    logic [31:0] exp_m;
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 3 || i == 6) set_ex(32'h60, 1'b1, 1'b0, 32'h900);
      else set_ex(32'h60, 1'b1, 1'b1, 32'h900);
      tick();
      clear_ex();
      wait_flush();
    end
`ifdef BRANCH_PERF_CNT_EN
    exp_b = 32'd10; exp_m = 32'd3;
`else
    exp_b = 32'd0; exp_m = 32'd0;
`endif
    checks++;
    if (BranchCnt !== exp_b) begin
      errors++;
      $display("FAIL branch_cnt got %0d exp %0d", BranchCnt, exp_b);
    end
    checks++;
    if (MispredCnt !== exp_m) begin
      errors++;
      $display("FAIL mispred_cnt got %0d exp %0d", MispredCnt, exp_m);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mispredict();
    test_saturate();
    test_stall_flush();
    test_reset_mid_flush();
    test_back_to_back();
    test_stall_idle();
    test_perf_cnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Branch scheduling controller for the 5-stage RISC-V pipeline. Sits beside the EX-stage branch condition logic.
- In IF it predicts direction from a table of 2-bit saturating counters (BHT).
- In EX it compares the resolved outcome (taken/not-taken from the branch condition unit) with the carried prediction.
- On mismatch it redirects the PC, sequences a multi-cycle flush of the younger stages, and trains the BHT.

Parameters:
- PC_W, 32, PC width in bits.
- IDX_BITS, 4, BHT index width; table has 2**IDX_BITS entries indexed by PC[IDX_BITS+1:2].
- FLUSH_CYC, 2, cycles Flush is held after a mispredict (IF/ID and ID/EX); legal range 1..7.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- IfPC  in  PC_W  PC of instruction in IF.
- IfBranch  in  1  predecode says IF instruction is a conditional branch.
- IfTarget  in  PC_W  IF-stage computed branch target.
- PredTaken  out  1  prediction for IF instruction (combinational).
- PredPC  out  PC_W  next PC: IfTarget if PredTaken, else IfPC+4.
- Stall  in  1  global pipeline stall; freezes EX acceptance and FSM.
- ExValid  in  1  EX stage holds a real (non-bubble) instruction.
- ExBranch  in  1  EX instruction is a conditional branch.
- ExTaken  in  1  resolved direction from branch condition unit.
- ExPredTaken  in  1  prediction carried down pipeline with the instruction.
- ExPC  in  PC_W  PC of EX instruction.
- ExTarget  in  PC_W  resolved branch target.
- Redirect  out  1  one-cycle pulse: fetch must load RedirectPC.
- RedirectPC  out  PC_W  corrected PC, registered.
- Flush  out  1  squash IF/ID and ID/EX contents.
- BranchCnt  out  32  resolved-branch count (see Optional Feature).
- MispredCnt  out  32  mispredict count (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async):
  - All BHT entries = 2'b01 (weakly not-taken).
  - FSM = IDLE; Redirect=0, RedirectPC=0, Flush=0.
  - Flush counter = 0; perf counters = 0.
  - Reset asserted mid-flush aborts the flush immediately.
- Predict:
  - PredTaken = IfBranch & BHT[IfPC idx][1]. Purely combinational, zero latency.
  - PredPC = PredTaken ? IfTarget : IfPC+4. Addition wraps modulo 2**PC_W.
- Resolve event: ExValid & ExBranch & !Stall & state==IDLE.
  - Mispredict = resolve & (ExTaken != ExPredTaken).
- BHT update on every resolve event, at the clock edge:
  - Taken: counter = min(counter+1, 3).
  - Not taken: counter = max(counter-1, 0). Saturates at 0 and 3, never wraps.
  - Same-cycle read and write of the same index: IF reads the pre-update value (no bypass).
- FSM states:
  - IDLE -> FLUSH on mispredict. Next cycle:
    - Redirect=1 for exactly 1 cycle.
    - RedirectPC = ExTaken ? ExTarget : ExPC+4.
    - Flush=1; counter loaded with FLUSH_CYC-1.
  - FLUSH: Flush=1 throughout.
    - Counter decrements only when !Stall; Stall holds Flush and the count.
    - Counter==0 and !Stall -> IDLE; Flush deasserts the following cycle. Flush is high for exactly FLUSH_CYC unstalled cycles.
    - No resolve events are accepted in FLUSH: EX contents are wrong-path. No BHT update, no counting, no nested redirect.
- Correct prediction: no Redirect, no Flush; BHT still trained.
- Non-branch or invalid EX instruction: no effect.
- Stall=1 in IDLE: EX resolve suppressed; the instruction is re-presented when the stall releases, so it is counted and trained once.

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- Defined:
  - BranchCnt increments on every resolve event.
  - MispredCnt increments on every mispredict.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by reset.
- Undefined: both outputs tied to 0 and no counter flops are built.

Test Plan:
- Reset, then IfBranch=1, IfPC=0x40 -> PredTaken=0, PredPC=0x44. Every index reads 2'b01.
- Taken branch at ExPC=0x40, ExPredTaken=0, ExTarget=0x100 ->
  - Next cycle: Redirect=1 for 1 cycle, RedirectPC=0x100.
  - Flush=1 for 2 cycles.
  - BHT[0]=2'b10; IF at 0x40 now predicts taken (PredPC=IfTarget).
- Four taken resolves at PC 0x40 with correct predictions -> BHT[0] saturates at 2'b11, no Redirect/Flush. Then one not-taken with ExPredTaken=1 -> RedirectPC=0x44, BHT[0]=2'b10.
- Mispredict, then Stall=1 for 3 cycles during FLUSH, and ExValid/ExBranch mispredicting in those cycles -> Flush stays high 5 cycles total, single Redirect pulse, BHT unchanged by wrong-path branch.
- rst_n dropped in the middle of FLUSH -> Flush and Redirect go 0 asynchronously, BHT back to 2'b01, FSM IDLE after release.
- With BRANCH_PERF_CNT_EN: 10 resolves, 3 mispredicts -> BranchCnt=10, MispredCnt=3. Preload near 0xFFFFFFFF, then one resolve -> wraps to 0. Without the macro both read 0.
